// File: rtl/m_inst_loader.sv
// m_inst_loader: writer-side front end for the microinstruction memory.
// Assembles MINST_WIDTH-bit words LSB-first from a valid/ready byte stream.
// Each word is written to the memory at sequential addresses from 0.
// When the load is complete, the memory is handed over to fetch mode.
//
// Ports:
//   sys_clk, sys_rst     - clock; synchronous active-high reset
//   load_start           - start pulse, honoured in IDLE/DONE only
//   load_count           - words to load; clamped to DEPTH and latched on start
//   byte_in, byte_valid  - byte stream input
//   byte_ready           - block can accept a byte
//   mode, m_pc           - memory mode and write address
//   m_inst_load          - memory write data (zero outside the write cycle)
//   load_busy            - block owns the memory (top level muxes m_pc on it)
//   load_done            - high once the load completes, until the next start
//   load_err             - checksum mismatch flag
//
// Build option: define M_INST_LOADER_CHECKSUM_EN to add a trailing checksum
// byte (the XOR of every data byte) that is compared after the last write.
module m_inst_loader #(
  parameter int MINST_WIDTH       = 44,
  parameter int DEPTH             = 1024,
  parameter int PC_WIDTH          = 10,
  parameter int M_INST_MODES      = 2,
  parameter int M_INST_LOAD_MODE  = 1,
  parameter int M_INST_FETCH_MODE = 2,
  parameter int M_INST_HOLD_MODE  = 0
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    load_start,
  input  logic [PC_WIDTH:0]       load_count,
  input  logic [7:0]              byte_in,
  input  logic                    byte_valid,
  output logic                    byte_ready,
  output logic [M_INST_MODES-1:0] mode,
  output logic [PC_WIDTH-1:0]     m_pc,
  output logic [MINST_WIDTH-1:0]  m_inst_load,
  output logic                    load_busy,
  output logic                    load_done,
  output logic                    load_err
);

  localparam int BYTES = (MINST_WIDTH + 7) / 8;
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int CW    = PC_WIDTH + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [M_INST_MODES-1:0] MODE_LOAD  = M_INST_MODES'(M_INST_LOAD_MODE);
  localparam logic [M_INST_MODES-1:0] MODE_FETCH = M_INST_MODES'(M_INST_FETCH_MODE);
  localparam logic [M_INST_MODES-1:0] MODE_HOLD  = M_INST_MODES'(M_INST_HOLD_MODE);

`ifdef M_INST_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE, S_CHECK} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE} state_t;
`endif

  state_t                 state_q, state_d;
  logic [CW-1:0]          addr_q;
  logic [CW-1:0]          count_q;
  logic [BCW-1:0]         byte_cnt_q;
  logic [MINST_WIDTH-1:0] word_q;
`ifdef M_INST_LOADER_CHECKSUM_EN
  logic [7:0]             csum_q;
  logic                   err_q;
`endif

  logic [CW-1:0] count_clamped;
  logic          start_ok;
  logic          xfer;
  logic          last_byte;
  logic          last_word;

  assign count_clamped = (load_count > DEPTH_C) ? DEPTH_C : load_count;
  assign start_ok      = load_start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign xfer          = byte_valid && byte_ready;
  assign last_byte     = (byte_cnt_q == BCW'(BYTES - 1));
  assign last_word     = ((addr_q + CW'(1)) == count_q);

  always_comb begin
    state_d     = state_q;
    byte_ready  = 1'b0;
    load_busy   = 1'b0;
    load_done   = 1'b0;
    mode        = MODE_HOLD;
    m_pc        = '0;
    m_inst_load = '0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (state_q == S_DONE) begin
          mode      = MODE_FETCH;
          load_done = 1'b1;
        end
        if (start_ok) begin
          if (count_clamped == '0) begin
`ifdef M_INST_LOADER_CHECKSUM_EN
            state_d = S_CHECK;
`else
            state_d = S_DONE;
`endif
          end else begin
            state_d = S_COLLECT;
          end
        end
      end
      S_COLLECT: begin
        byte_ready = 1'b1;
        load_busy  = 1'b1;
        m_pc       = addr_q[PC_WIDTH-1:0];
        if (xfer && last_byte) state_d = S_WRITE;
      end
      S_WRITE: begin
        load_busy   = 1'b1;
        mode        = MODE_LOAD;
        m_pc        = addr_q[PC_WIDTH-1:0];
        m_inst_load = word_q;
        if (last_word) begin
`ifdef M_INST_LOADER_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_COLLECT;
        end
      end
`ifdef M_INST_LOADER_CHECKSUM_EN
      S_CHECK: begin
        byte_ready = 1'b1;
        load_busy  = 1'b1;
        m_pc       = addr_q[PC_WIDTH-1:0];
        if (xfer) state_d = S_DONE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      count_q    <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
`ifdef M_INST_LOADER_CHECKSUM_EN
      csum_q     <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        addr_q     <= '0;
        count_q    <= count_clamped;
        byte_cnt_q <= '0;
        word_q     <= '0;
`ifdef M_INST_LOADER_CHECKSUM_EN
        csum_q     <= '0;
        err_q      <= 1'b0;
`endif
      end
      if (state_q == S_COLLECT && xfer) begin
        // Per-bit placement keeps the final byte's bits above MINST_WIDTH-1 out of the word.
        for (int unsigned i = 0; i < MINST_WIDTH; i++) begin
          if (byte_cnt_q == BCW'(i / 8)) word_q[i] <= byte_in[i % 8];
        end
        byte_cnt_q <= byte_cnt_q + BCW'(1);
`ifdef M_INST_LOADER_CHECKSUM_EN
        csum_q     <= csum_q ^ byte_in;
`endif
      end
      if (state_q == S_WRITE) begin
        addr_q     <= addr_q + CW'(1);
        byte_cnt_q <= '0;
      end
`ifdef M_INST_LOADER_CHECKSUM_EN
      if (state_q == S_CHECK && xfer && (byte_in != csum_q)) err_q <= 1'b1;
`endif
    end
  end

`ifdef M_INST_LOADER_CHECKSUM_EN
  assign load_err = err_q;
`else
  assign load_err = 1'b0;
`endif

endmodule

// File: tb/tb_m_inst_loader.sv
module tb_m_inst_loader;
  localparam int MW    = 44;
  localparam int PW    = 10;
  localparam int DEPTH = 1024;
  localparam int NB    = (MW + 7) / 8;

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic          load_start;
  logic [PW:0]   load_count;
  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          byte_ready;
  logic [1:0]    mode;
  logic [PW-1:0] m_pc;
  logic [MW-1:0] m_inst_load;
  logic          load_busy;
  logic          load_done;
  logic          load_err;

  always #5 sys_clk = ~sys_clk;

  m_inst_loader #(
    .MINST_WIDTH(MW),
    .DEPTH(DEPTH),
    .PC_WIDTH(PW),
    .M_INST_MODES(2),
    .M_INST_LOAD_MODE(1),
    .M_INST_FETCH_MODE(2),
    .M_INST_HOLD_MODE(0)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .load_start(load_start),
    .load_count(load_count),
    .byte_in(byte_in),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .mode(mode),
    .m_pc(m_pc),
    .m_inst_load(m_inst_load),
    .load_busy(load_busy),
    .load_done(load_done),
    .load_err(load_err)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0]    data_bytes[$];
  logic [7:0]    stream[$];
  int unsigned   wr_pc[$];
  logic [MW-1:0] wr_data[$];
  logic          wr_rdy[$];
  int            data_leak = 0;

  // Record every write cycle seen on the memory interface.
  always @(negedge sys_clk) begin
    if (mode == 2'd1) begin
      wr_pc.push_back(int'(m_pc));
      wr_data.push_back(m_inst_load);
      wr_rdy.push_back(byte_ready);
    end else if (m_inst_load !== '0) begin
      data_leak++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_csum();
    logic [7:0] x;
    x = 8'h00;
    foreach (data_bytes[i]) x = x ^ data_bytes[i];
    return x;
  endfunction

  function automatic logic [63:0] model_word(input int k);
    logic [63:0] w;
    w = 64'd0;
    for (int j = 0; j < NB; j++) w = w | (64'(data_bytes[k*NB + j]) << (8*j));
    return w & ((64'd1 << MW) - 64'd1);
  endfunction

  task automatic fill_random(input int nwords);
    data_bytes.delete();
    for (int i = 0; i < nwords*NB; i++) data_bytes.push_back(8'($urandom_range(255)));
  endtask

  task automatic finalize(input logic [7:0] bad);
    stream.delete();
    foreach (data_bytes[i]) stream.push_back(data_bytes[i]);
`ifdef M_INST_LOADER_CHECKSUM_EN
    stream.push_back(model_csum() ^ bad);
`else
    if (bad != 8'h00) stream.push_back(8'h00);
    if (bad != 8'h00) void'(stream.pop_back());
`endif
  endtask

  task automatic clear_writes();
    wr_pc.delete();
    wr_data.delete();
    wr_rdy.delete();
  endtask

  task automatic start(input int cnt);
    @(negedge sys_clk);
    load_start = 1'b1;
    load_count = cnt[PW:0];
    @(negedge sys_clk);
    load_start = 1'b0;
    load_count = (PW+1)'($urandom);
  endtask

  // gap: 0 = always valid, 1 = valid on alternate cycles, 2 = random gaps
  task automatic send(input string tag, input int n, input int gap);
    int sent;
    int budget;
    sent = 0;
    budget = 0;
    while (sent < n && budget < 20000) begin
      @(negedge sys_clk);
      case (gap)
        0:       byte_valid = 1'b1;
        1:       byte_valid = budget[0];
        default: byte_valid = ($urandom_range(99) >= 40);
      endcase
      byte_in = (byte_valid && stream.size() > 0) ? stream[0] : 8'($urandom);
      if (byte_valid && byte_ready && stream.size() > 0) begin
        void'(stream.pop_front());
        sent++;
      end
      budget++;
    end
    @(negedge sys_clk);
    byte_valid = 1'b0;
    byte_in    = 8'($urandom);
    check({tag, "_sent"}, sent, n);
  endtask

  task automatic wait_done(input string tag);
    int b;
    b = 0;
    while (!load_done && b < 1000) begin
      @(negedge sys_clk);
      b++;
    end
    check({tag, "_done"}, load_done, 1);
  endtask

  task automatic verify_writes(input string tag, input int nwords);
    check({tag, "_nwrites"}, wr_pc.size(), nwords);
    for (int k = 0; k < nwords && k < wr_pc.size(); k++) begin
      check({tag, "_pc"}, wr_pc[k], k);
      check({tag, "_data"}, wr_data[k], model_word(k));
      check({tag, "_rdy_in_write"}, wr_rdy[k], 0);
    end
  endtask

  task automatic do_load(input string tag, input int cnt, input int nexp, input int gap, input logic exp_err);
    clear_writes();
    start(cnt);
    send(tag, stream.size(), gap);
    wait_done(tag);
    verify_writes(tag, nexp);
    check({tag, "_mode_fetch"}, mode, 2);
    check({tag, "_busy"}, load_busy, 0);
    check({tag, "_pc_idle"}, m_pc, 0);
`ifdef M_INST_LOADER_CHECKSUM_EN
    check({tag, "_err"}, load_err, exp_err);
`else
    check({tag, "_err"}, load_err, 0);
`endif
  endtask

  initial begin
    logic [7:0] bad;
    int n;

    sys_rst    = 1'b1;
    load_start = 1'b0;
    load_count = '0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    check("rst_mode", mode, 0);
    check("rst_ready", byte_ready, 0);
    check("rst_busy", load_busy, 0);
    check("rst_done", load_done, 0);
    check("rst_data", m_inst_load, 0);
    check("rst_pc", m_pc, 0);
    check("rst_err", load_err, 0);
    sys_rst = 1'b0;

    // Directed two-word load, continuous stream.
    data_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'hF6,
                   8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
    finalize(8'h00);
    do_load("dir2", 2, 2, 0, 1'b0);
    if (wr_data.size() >= 2) begin
      check("dir2_w0_const", wr_data[0], 44'h60504030201);
      check("dir2_w1_const", wr_data[1], 44'h61514131211);
    end

    // Same stream with alternate-cycle gaps.
    finalize(8'h00);
    do_load("gaps", 2, 2, 1, 1'b0);

    // Zero-count load.
    clear_writes();
    start(0);
`ifdef M_INST_LOADER_CHECKSUM_EN
    check("zero_check_ready", byte_ready, 1);
    data_bytes.delete();
    finalize(8'h00);
    send("zero", 1, 0);
`else
    check("zero_done_1cyc", load_done, 1);
`endif
    wait_done("zero");
    check("zero_nwrites", wr_pc.size(), 0);
    check("zero_err", load_err, 0);

    // Start pulse during COLLECT is ignored.
    fill_random(1);
    finalize(8'h00);
    clear_writes();
    start(1);
    send("ign_a", 3, 0);
    @(negedge sys_clk);
    load_start = 1'b1;
    load_count = 11'd5;
    @(negedge sys_clk);
    load_start = 1'b0;
    check("ign_busy", load_busy, 1);
    send("ign_b", stream.size(), 0);
    wait_done("ign");
    verify_writes("ign", 1);

    // Reset part-way through the first word.
    fill_random(1);
    finalize(8'h00);
    clear_writes();
    start(1);
    send("mid", 3, 0);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    check("mid_busy", load_busy, 0);
    check("mid_done", load_done, 0);
    check("mid_mode", mode, 0);
    check("mid_ready", byte_ready, 0);
    check("mid_nwrites", wr_pc.size(), 0);
    data_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    finalize(8'h00);
    do_load("restart", 1, 1, 0, 1'b0);
    if (wr_data.size() >= 1) check("restart_const", wr_data[0], 44'h60504030201);

    // Checksum mismatch.
    finalize(8'h0F);
    do_load("badsum", 1, 1, 0, 1'b1);

    // Randomized loads.
    for (int r = 0; r < 5; r++) begin
      n = $urandom_range(1, 4);
      fill_random(n);
      bad = ($urandom_range(1) == 1) ? 8'($urandom_range(1, 255)) : 8'h00;
      finalize(bad);
      do_load("rand", n, n, 2, bad != 8'h00);
    end

    // Oversized count clamps to DEPTH.
    fill_random(DEPTH);
    finalize(8'h00);
    do_load("clamp", 2047, DEPTH, 0, 1'b0);

    check("no_data_outside_write", data_leak, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
